// File: rtl/rob_commit_pkg.sv
// Shared core parameters and types for the reorder buffer.
//   RF_SIZE_LOG / REG_LEN : register file index and data widths.
//   ROB_SIZE / ROB_SIZE_LOG : entry count (power of 2) and tag width.
// The tag and pointer types are derived from ROB_SIZE_LOG so that every
// user of the ROB agrees on their widths.
package rob_commit_pkg;

  localparam int RF_SIZE_LOG  = 5;
  localparam int REG_LEN      = 32;
  localparam int ROB_SIZE     = 4;
  localparam int ROB_SIZE_LOG = 2;

  typedef logic [RF_SIZE_LOG-1:0]  rf_idx_t;
  typedef logic [REG_LEN-1:0]      reg_data_t;
  typedef logic [ROB_SIZE_LOG-1:0] rob_tag_t;
  // Pointer carries one extra wrap bit above the tag bits.
  typedef logic [ROB_SIZE_LOG:0]   rob_ptr_t;

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch / writeback / commit bundle of the reorder buffer.
//   alloc_* : dispatch handshake (valid/ready) plus the assigned tag.
//   wb_*    : out-of-order completion by ROB tag.
//   squash  : flush of all in-flight entries.
//   commit_*: retirement, drives the register file write port.
//   empty / count : occupancy status.
// Modport slave is the ROB itself; master is the core side.
interface rob_commit_if;
  import rob_commit_pkg::*;

  logic      alloc_valid;
  logic      alloc_wen;
  rf_idx_t   alloc_rd;
  logic      alloc_ready;
  rob_tag_t  alloc_tag;
  logic      wb_valid;
  rob_tag_t  wb_tag;
  reg_data_t wb_data;
  logic      squash;
  logic      commit_wen;
  rf_idx_t   commit_rd;
  reg_data_t commit_data;
  logic      commit_valid;
  logic      empty;
  rob_ptr_t  count;

  modport slave (
    input  alloc_valid, alloc_wen, alloc_rd, wb_valid, wb_tag, wb_data, squash,
    output alloc_ready, alloc_tag, commit_wen, commit_rd, commit_data,
           commit_valid, empty, count
  );

  modport master (
    output alloc_valid, alloc_wen, alloc_rd, wb_valid, wb_tag, wb_data, squash,
    input  alloc_ready, alloc_tag, commit_wen, commit_rd, commit_data,
           commit_valid, empty, count
  );

endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer. Entries are allocated at dispatch, completed
// out of order by tag, and retired one per cycle in program order; the
// registered commit outputs drive the register file write port.
// Ports:
//   clk, rst : clock, synchronous active-high reset.
//   rif      : rob_commit_if.slave (alloc, writeback, squash, commit, status).
// Optional feature, macro ROB_WB_BYPASS_EN: a writeback hitting the head
// entry retires it in the same cycle (commit_data taken from wb_data),
// saving one cycle of writeback-to-RF latency. Default build uses only the
// registered done bit.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  rob_commit_if.slave   rif
);

  // Per-entry state, indexed by pointer low bits.
  logic [ROB_SIZE-1:0] valid_q;
  logic [ROB_SIZE-1:0] done_q;
  logic [ROB_SIZE-1:0] wen_q;
  rf_idx_t             rd_q   [ROB_SIZE];
  reg_data_t           data_q [ROB_SIZE];

  rob_ptr_t  head, tail;
  rob_tag_t  head_idx, tail_idx;
  logic      full, alloc_fire, wb_hit, pop;
  reg_data_t pop_data;

  assign head_idx = head[ROB_SIZE_LOG-1:0];
  assign tail_idx = tail[ROB_SIZE_LOG-1:0];

  assign full = (head_idx == tail_idx) && (head[ROB_SIZE_LOG] != tail[ROB_SIZE_LOG]);

  // Ready looks only at registered pointers, so a same-cycle pop never
  // opens a slot early.
  assign rif.alloc_ready = !full;
  assign rif.alloc_tag   = tail_idx;
  assign rif.empty       = (head == tail);
  assign rif.count       = tail - head;

  assign alloc_fire = rif.alloc_valid && !full && !rif.squash;
  assign wb_hit     = rif.wb_valid && valid_q[rif.wb_tag] && !rif.squash;

`ifdef ROB_WB_BYPASS_EN
  logic head_bypass;
  assign head_bypass = wb_hit && (rif.wb_tag == head_idx);
  assign pop         = valid_q[head_idx] && (done_q[head_idx] || head_bypass) && !rif.squash;
  assign pop_data    = head_bypass ? rif.wb_data : data_q[head_idx];
`else
  assign pop         = valid_q[head_idx] && done_q[head_idx] && !rif.squash;
  assign pop_data    = data_q[head_idx];
`endif

  // Control state: pointers, valid/done, commit strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      done_q           <= '0;
      head             <= '0;
      tail             <= '0;
      rif.commit_valid <= 1'b0;
      rif.commit_wen   <= 1'b0;
      rif.commit_rd    <= '0;
      rif.commit_data  <= '0;
    end else if (rif.squash) begin
      // Outputs from the previous pop already went out this cycle; only
      // the next cycle's strobes are suppressed.
      valid_q          <= '0;
      head             <= '0;
      tail             <= '0;
      rif.commit_valid <= 1'b0;
      rif.commit_wen   <= 1'b0;
    end else begin
      if (wb_hit)
        done_q[rif.wb_tag] <= 1'b1;
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail              <= tail + rob_ptr_t'(1);
      end
      if (pop) begin
        valid_q[head_idx] <= 1'b0;
        head              <= head + rob_ptr_t'(1);
        rif.commit_rd     <= rd_q[head_idx];
        rif.commit_data   <= pop_data;
      end
      rif.commit_valid <= pop;
      rif.commit_wen   <= pop && wen_q[head_idx];
    end
  end

  // Payload arrays need no reset; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (!rst && alloc_fire) begin
      wen_q[tail_idx] <= rif.alloc_wen;
      rd_q[tail_idx]  <= rif.alloc_rd;
    end
    if (!rst && wb_hit)
      data_q[rif.wb_tag] <= rif.wb_data;
  end

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    int        cyc;
    logic      wen;
    rf_idx_t   rd;
    reg_data_t data;
  } cmt_t;

  cmt_t      cq [$];
  reg_data_t rf [2**RF_SIZE_LOG];

  rob_commit_if rif ();

  rob_commit dut (
    .clk (clk),
    .rst (rst),
    .rif (rif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model fed by the commit port.
  always @(posedge clk) if (rif.commit_wen) rf[rif.commit_rd] <= rif.commit_data;

  // Record every retirement with the cycle it was visible in.
  always @(negedge clk) begin
    cmt_t c;
    if (rif.commit_valid) begin
      c.cyc  = cyc;
      c.wen  = rif.commit_wen;
      c.rd   = rif.commit_rd;
      c.data = rif.commit_data;
      cq.push_back(c);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    rif.alloc_valid = 1'b0;
    rif.alloc_wen   = 1'b0;
    rif.alloc_rd    = '0;
    rif.wb_valid    = 1'b0;
    rif.wb_tag      = '0;
    rif.wb_data     = '0;
    rif.squash      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    cq.delete();
  endtask

  task automatic alloc(input logic wen, input int rd);
    rif.alloc_valid = 1'b1;
    rif.alloc_wen   = wen;
    rif.alloc_rd    = rf_idx_t'(rd);
    tick();
    rif.alloc_valid = 1'b0;
  endtask

  // Drive one writeback this cycle; returns the cycle it was presented in.
  task automatic wb(input int tag, input int data, output int wcyc);
    rif.wb_valid = 1'b1;
    rif.wb_tag   = rob_tag_t'(tag);
    rif.wb_data  = reg_data_t'(data);
    wcyc = cyc;
    tick();
    rif.wb_valid = 1'b0;
  endtask

  int w, w0;

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick(2);

    // Reset state
    chk("rst_ready", rif.alloc_ready, 1);
    chk("rst_empty", rif.empty, 1);
    chk("rst_count", rif.count, 0);
    chk("rst_tag", rif.alloc_tag, 0);
    chk("rst_cvalid", rif.commit_valid, 0);
    chk("rst_cwen", rif.commit_wen, 0);
    chk("rst_crd", rif.commit_rd, 0);
    chk("rst_cdata", rif.commit_data, 0);
    rst = 1'b0;

    // Single alloc / wb / commit, two-cycle latency
    alloc(1'b1, 3);
    chk("t1_count", rif.count, 1);
    chk("t1_empty", rif.empty, 0);
    wb(0, 'h5A, w);
    chk("t1_nocommit_yet", rif.commit_valid, 0);
    tick(3);
    chk("t1_ncommit", cq.size(), 1);
    if (cq.size() == 1) begin
      chk("t1_cyc", cq[0].cyc, w + 2);
      chk("t1_wen", cq[0].wen, 1);
      chk("t1_rd", cq[0].rd, 3);
      chk("t1_data", cq[0].data, 'h5A);
    end
    chk("t1_empty_after", rif.empty, 1);
    chk("t1_rf3", rf[3], 'h5A);
    chk("t1_hold_valid", rif.commit_valid, 0);
    chk("t1_hold_wen", rif.commit_wen, 0);
    chk("t1_hold_rd", rif.commit_rd, 3);
    chk("t1_hold_data", rif.commit_data, 'h5A);

    // Fill to full, rejected 5th alloc, in-order drain
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("t2_tag", rif.alloc_tag, i);
      alloc(1'b1, i + 1);
    end
    chk("t2_ready_full", rif.alloc_ready, 0);
    chk("t2_count_full", rif.count, 4);
    alloc(1'b1, 9);
    chk("t2_count_rej", rif.count, 4);
    chk("t2_tag_rej", rif.alloc_tag, 0);
    chk("t2_ready_rej", rif.alloc_ready, 0);
    for (int i = 0; i < 4; i++) begin
      wb(i, 'h20 + i, w);
      if (i == 0) w0 = w;
    end
    tick(3);
    chk("t2_ncommit", cq.size(), 4);
    for (int i = 0; i < 4 && i < cq.size(); i++) begin
      chk("t2_cyc", cq[i].cyc, w0 + 2 + i);
      chk("t2_rd", cq[i].rd, i + 1);
      chk("t2_data", cq[i].data, 'h20 + i);
    end
    chk("t2_empty", rif.empty, 1);

    // Reverse-order writeback retires in program order
    do_reset();
    for (int i = 0; i < 3; i++) alloc(1'b1, 10 + i);
    wb(2, 'h32, w);
    wb(1, 'h31, w);
    wb(0, 'h30, w0);
    tick(4);
    chk("t3_ncommit", cq.size(), 3);
    for (int i = 0; i < 3 && i < cq.size(); i++) begin
      chk("t3_cyc", cq[i].cyc, w0 + 2 + i);
      chk("t3_rd", cq[i].rd, 10 + i);
      chk("t3_data", cq[i].data, 'h30 + i);
    end

    // Non-writing instruction retires without touching the RF
    do_reset();
    alloc(1'b1, 7);
    wb(0, 'h77, w);
    tick(3);
    chk("t4_rf7_first", rf[7], 'h77);
    cq.delete();
    alloc(1'b0, 7);
    wb(1, 'h99, w);
    tick(3);
    chk("t4_ncommit", cq.size(), 1);
    if (cq.size() == 1) begin
      chk("t4_cvalid_cyc", cq[0].cyc, w + 2);
      chk("t4_wen0", cq[0].wen, 0);
    end
    chk("t4_rf7_kept", rf[7], 'h77);

    // Three fill/drain rounds across the pointer wrap
    do_reset();
    for (int r = 0; r < 3; r++) begin
      cq.delete();
      for (int i = 0; i < 4; i++) begin
        chk("t5_tag", rif.alloc_tag, i);
        chk("t5_count", rif.count, i);
        alloc(1'b1, 16 + i);
      end
      chk("t5_count_full", rif.count, 4);
      for (int i = 0; i < 4; i++) wb(i, 'h100 * (r + 1) + i, w);
      tick(3);
      chk("t5_count_drained", rif.count, 0);
      chk("t5_ncommit", cq.size(), 4);
      for (int i = 0; i < 4 && i < cq.size(); i++)
        chk("t5_data", cq[i].data, 'h100 * (r + 1) + i);
    end

    // Squash (then reset) while writing back the head
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < 3; i++) alloc(1'b1, 20 + i);
      wb(1, 'h41, w);
      rif.wb_valid = 1'b1;
      rif.wb_tag   = '0;
      rif.wb_data  = 'h40;
      if (k == 0) rif.squash = 1'b1;
      else        rst = 1'b1;
      tick();
      idle_inputs();
      rst = 1'b0;
      chk(k == 0 ? "t6_sq_count" : "t6_rst_count", rif.count, 0);
      chk(k == 0 ? "t6_sq_tag" : "t6_rst_tag", rif.alloc_tag, 0);
      chk(k == 0 ? "t6_sq_ready" : "t6_rst_ready", rif.alloc_ready, 1);
      chk(k == 0 ? "t6_sq_empty" : "t6_rst_empty", rif.empty, 1);
      tick(4);
      chk(k == 0 ? "t6_sq_nocommit" : "t6_rst_nocommit", cq.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
